// File: rtl/aes_cipher_stream.sv
// Streaming AES-128 encryptor: iterative one-round-per-clock core with a key cache,
// valid/ready handshakes and a credit-reserved first-word-fall-through output FIFO.
module aes_cipher_stream #(
    parameter int unsigned OFIFO_DEPTH = 2,
    parameter int unsigned TAG_W       = 4,
    parameter int unsigned NR          = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_key_new,
    input  logic [127:0]     in_key,
    input  logic [127:0]     in_text,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_text,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);
    localparam int unsigned CNT_W = $clog2(OFIFO_DEPTH + 1);
    localparam int unsigned PTR_W = (OFIFO_DEPTH > 1) ? $clog2(OFIFO_DEPTH) : 1;
    localparam int unsigned RC_W  = 4;

    if (NR != 10) begin : g_nr_check
        $error("aes_cipher_stream: NR must be 10 (AES-128)");
    end
    if (OFIFO_DEPTH == 0 || (OFIFO_DEPTH & (OFIFO_DEPTH - 1)) != 0) begin : g_depth_check
        $error("aes_cipher_stream: OFIFO_DEPTH must be a power of 2");
    end

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [2:0] {S_IDLE, S_KEXP, S_INIT, S_ROUND, S_FINAL} state_t;

    // Entry x sits at bits [2047-8x -: 8]; 2047-8x == {~x, 3'b111}.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[{~x, 3'b111} -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        int           src;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            src = 4 * (((i / 4) + (i % 4)) % 4) + (i % 4);
            o[127 - 8*i -: 8] = sbox(s[127 - 8*src -: 8]);
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            o[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    function automatic logic [127:0] key_next(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, w0, w1, w2, w3;
        t  = {sbox(k[23:16]) ^ rc, sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])};
        w0 = k[127:96] ^ t;
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    state_t            r_state, w_state_nxt;
    logic [RC_W-1:0]   r_rcnt;
    logic [127:0]      r_key_cache, r_text, r_rk, r_sd;
    logic [7:0]        r_rcon;
    logic [TAG_W-1:0]  r_tag;
    logic [127:0]      r_mem_text [OFIFO_DEPTH];
    logic [TAG_W-1:0]  r_mem_tag  [OFIFO_DEPTH];
    logic [PTR_W-1:0]  r_wptr, r_rptr;
    logic [CNT_W-1:0]  r_count, r_credit;
    logic              w_accept, w_pop, w_kld, w_init, w_round, w_push;

    assign w_accept = in_valid & in_ready;
    assign w_pop    = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_KEXP;
            S_KEXP:  w_state_nxt = S_INIT;
            S_INIT:  w_state_nxt = S_ROUND;
            S_ROUND: if (r_rcnt == RC_W'(NR - 1)) w_state_nxt = S_FINAL;
            S_FINAL: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        w_kld    = 1'b0;
        w_init   = 1'b0;
        w_round  = 1'b0;
        w_push   = 1'b0;
        case (r_state)
            S_IDLE:  in_ready = rst && (r_credit != '0);
            S_KEXP:  w_kld    = 1'b1;
            S_INIT:  w_init   = 1'b1;
            S_ROUND: w_round  = 1'b1;
            S_FINAL: w_push   = 1'b1;
            default: ;
        endcase
    end

    // Block datapath: key cache, round key schedule generated on the fly, cipher state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_key_cache <= '0;
            r_text      <= '0;
            r_tag       <= '0;
            r_rk        <= '0;
            r_rcon      <= '0;
            r_sd        <= '0;
            r_rcnt      <= '0;
        end else begin
            if (w_accept) begin
                r_text <= in_text;
                r_tag  <= in_tag;
                if (in_key_new) r_key_cache <= in_key;
            end
            if (w_kld) begin
                r_rk   <= r_key_cache;
                r_rcon <= 8'h01;
            end
            if (w_init || w_round) begin
                r_sd   <= w_init ? (r_text ^ r_rk) : (mix_columns(sub_shift(r_sd)) ^ r_rk);
                r_rk   <= key_next(r_rk, r_rcon);
                r_rcon <= xtime(r_rcon);
                r_rcnt <= w_init ? RC_W'(1) : r_rcnt + RC_W'(1);
            end
            if (w_push) r_rcnt <= '0;
        end
    end

    // Output FIFO; credit reserves a slot at accept so the final push never stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(OFIFO_DEPTH); i++) begin
                r_mem_text[i] <= '0;
                r_mem_tag[i]  <= '0;
            end
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_credit <= CNT_W'(OFIFO_DEPTH);
        end else begin
            if (w_push) begin
                r_mem_text[r_wptr] <= sub_shift(r_sd) ^ r_rk;
                r_mem_tag[r_wptr]  <= r_tag;
                r_wptr <= (r_wptr == PTR_W'(OFIFO_DEPTH - 1)) ? '0 : r_wptr + PTR_W'(1);
            end
            if (w_pop)
                r_rptr <= (r_rptr == PTR_W'(OFIFO_DEPTH - 1)) ? '0 : r_rptr + PTR_W'(1);
            if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
            else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
            if (w_accept && !w_pop)      r_credit <= r_credit - CNT_W'(1);
            else if (!w_accept && w_pop) r_credit <= r_credit + CNT_W'(1);
        end
    end

    assign out_valid = (r_count != '0);
    assign out_text  = r_mem_text[r_rptr];
    assign out_tag   = r_mem_tag[r_rptr];
    assign busy      = (r_state != S_IDLE) || (r_count != '0);

endmodule

// File: tb/tb_aes_cipher_stream.sv
// Directed bench for aes_cipher_stream: known-answer vectors, latency, key cache,
// backpressure, back-to-back throughput, mid-block reset and same-cycle push/pop.
module tb_aes_cipher_stream;
    localparam logic [127:0] K_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P_C1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] C_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] K_F  = {128{1'b1}};

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, in_key_new;
    logic [127:0] in_key, in_text;
    logic [3:0]   in_tag;
    logic         out_valid, out_ready;
    logic [127:0] out_text;
    logic [3:0]   out_tag;
    logic         busy;

    int n_checks = 0;
    int n_errors = 0;

    aes_cipher_stream #(.OFIFO_DEPTH(2), .TAG_W(4), .NR(10)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_key_new(in_key_new),
        .in_key(in_key), .in_text(in_text), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_text(out_text), .out_tag(out_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [127:0] k, input logic [127:0] p, input logic [3:0] t,
                         input logic kn);
        in_valid   = 1'b1;
        in_key     = k;
        in_text    = p;
        in_tag     = t;
        in_key_new = kn;
    endtask

    // Waits (bounded) for in_ready, lets the accept edge pass, then drops in_valid.
    task automatic accept_block(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (in_ready) begin
                ok = 1'b1;
                tick();
                break;
            end
            tick();
        end
        in_valid = 1'b0;
        check({name, "_accept"}, 128'(ok), 128'd1);
    endtask

    task automatic wait_result(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            tick();
            cyc++;
        end
    endtask

    task automatic run_block(input string name, input logic [127:0] k, input logic [127:0] p,
                             input logic [3:0] t, input logic kn, input logic [127:0] exp);
        int cyc;
        offer(k, p, t, kn);
        accept_block(name);
        wait_result(cyc);
        check({name, "_latency"}, 128'(cyc), 128'd12);
        check({name, "_ct"}, out_text, exp);
        check({name, "_tag"}, 128'(out_tag), 128'(t));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({name, "_popped"}, 128'(out_valid), 128'd0);
    endtask

    logic [127:0] bk_key [4];
    logic [127:0] bk_pt  [4];
    logic [127:0] bk_ct  [4];
    logic [3:0]   bk_tag [4];
    logic         bk_kn  [4];

    initial begin
        int cyc, highs, ai, oi, n;
        int acc_cyc [4];
        bit accepting;

        rst = 1'b0; in_valid = 1'b0; in_key_new = 1'b0; in_key = '0; in_text = '0;
        in_tag = '0; out_ready = 1'b0;
        tick();
        tick();
        check("rst_in_ready", 128'(in_ready), 128'd0);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_out_text", out_text, 128'd0);
        check("rst_out_tag", 128'(out_tag), 128'd0);
        rst = 1'b1;
        #1;
        check("rel_in_ready", 128'(in_ready), 128'd1);

        run_block("c1", K_C1, P_C1, 4'd3, 1'b1, C_C1);
        check("c1_idle_busy", 128'(busy), 128'd0);
        run_block("cache", K_F, P_C1, 4'd5, 1'b0, C_C1);

        // Backpressure: two results fill the FIFO, a third block must wait.
        offer(K_F, '0, 4'd1, 1'b1);
        offer('0, '0, 4'd1, 1'b1);
        accept_block("bp_a");
        offer(K_B, P_B, 4'd2, 1'b1);
        accept_block("bp_b");
        offer(K_C1, P_C1, 4'd6, 1'b1);
        highs = 0;
        for (int i = 0; i < 30; i++) begin
            if (in_ready) highs++;
            tick();
        end
        check("bp_hold", 128'(highs), 128'd0);
        check("bp_head_ct", out_text, C_Z);
        check("bp_head_tag", 128'(out_tag), 128'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_ready_after_pop", 128'(in_ready), 128'd1);
        check("bp_next_tag", 128'(out_tag), 128'd2);
        check("bp_next_ct", out_text, C_B);
        tick();
        in_valid = 1'b0;
        // Block C pushes at the 12th edge after accept; pop B on that same edge.
        for (int i = 0; i < 11; i++) tick();
        check("pp_pre_tag", 128'(out_tag), 128'd2);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("pp_valid", 128'(out_valid), 128'd1);
        check("pp_tag", 128'(out_tag), 128'd6);
        check("pp_ct", out_text, C_C1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("pp_count_one", 128'(out_valid), 128'd0);

        // Back-to-back with in_valid held and out_ready high.
        bk_key[0] = K_C1; bk_pt[0] = P_C1; bk_ct[0] = C_C1; bk_tag[0] = 4'd1; bk_kn[0] = 1'b1;
        bk_key[1] = K_B;  bk_pt[1] = P_B;  bk_ct[1] = C_B;  bk_tag[1] = 4'd2; bk_kn[1] = 1'b1;
        bk_key[2] = '0;   bk_pt[2] = '0;   bk_ct[2] = C_Z;  bk_tag[2] = 4'd3; bk_kn[2] = 1'b1;
        bk_key[3] = K_F;  bk_pt[3] = '0;   bk_ct[3] = C_Z;  bk_tag[3] = 4'd4; bk_kn[3] = 1'b0;
        out_ready = 1'b1;
        ai = 0; oi = 0; n = 0;
        offer(bk_key[0], bk_pt[0], bk_tag[0], bk_kn[0]);
        while (oi < 4 && n < 200) begin
            if (out_valid) begin
                check($sformatf("b2b_ct%0d", oi), out_text, bk_ct[oi]);
                check($sformatf("b2b_tag%0d", oi), 128'(out_tag), 128'(bk_tag[oi]));
                oi++;
            end
            accepting = in_valid && in_ready;
            if (accepting) acc_cyc[ai] = n + 1;
            tick();
            n++;
            if (accepting) begin
                ai++;
                if (ai < 4) offer(bk_key[ai], bk_pt[ai], bk_tag[ai], bk_kn[ai]);
                else in_valid = 1'b0;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b_results", 128'(oi), 128'd4);
        for (int i = 1; i < 4; i++)
            check($sformatf("b2b_gap%0d", i), 128'(acc_cyc[i] - acc_cyc[i-1]), 128'd13);

        // Reset in round 5: block is dropped and the key cache returns to zero.
        offer(K_C1, P_C1, 4'd7, 1'b1);
        accept_block("mid");
        for (int i = 0; i < 7; i++) tick();
        check("mid_busy_before", 128'(busy), 128'd1);
        rst = 1'b0;
        #1;
        check("mid_rst_busy", 128'(busy), 128'd0);
        check("mid_rst_in_ready", 128'(in_ready), 128'd0);
        tick();
        rst = 1'b1;
        #1;
        check("mid_rel_in_ready", 128'(in_ready), 128'd1);
        highs = 0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid) highs++;
            tick();
        end
        check("mid_nothing_out", 128'(highs), 128'd0);
        run_block("zero_key", K_B, '0, 4'd9, 1'b0, C_Z);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
